// File: rtl/strip_trigger_info_receiver.sv
// Strip trigger serial link receiver: synchronises the link lines into clk,
// deserialises 32-bit frames and checks framing. Macro: STRIP_TRIG_RX_PARITY_EN.
module strip_trigger_info_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trig_clk,
    input  logic        trig_en,
    input  logic        trig_d0,
    input  logic        trig_d1,
    output logic [7:0]  band_id,
    output logic [5:0]  phi_id,
    output logic [11:0] bcid,
    output logic        data_valid,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [15:0] frame_count,
    output logic [15:0] err_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

`ifdef STRIP_TRIG_RX_PARITY_EN
    localparam bit PAR_CHK = 1'b1;
`else
    localparam bit PAR_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] en_sync;
    logic [SYNC_STAGES-1:0] d0_sync;
    logic [SYNC_STAGES-1:0] d1_sync;
    logic                   tclk_prev;

    logic [31:0]   shreg;
    logic [4:0]    pair_cnt;
    logic [TW-1:0] idle_cnt;

    logic       tclk_s;
    logic       en_s;
    logic       d0_s;
    logic       d1_s;
    logic       link_edge;
    logic       do_shift;
    logic       err_n;
    logic [1:0] code_n;
    logic       good;
    logic       bad;

    assign tclk_s    = clk_sync[SYNC_STAGES-1];
    assign en_s      = en_sync[SYNC_STAGES-1];
    assign d0_s      = d0_sync[SYNC_STAGES-1];
    assign d1_s      = d1_sync[SYNC_STAGES-1];
    assign link_edge = tclk_s & ~tclk_prev;

    // Reserved bits must be zero; the parity term only bites when enabled.
    assign bad = (|shreg[5:1]) | (PAR_CHK & (^shreg));

    // Synchroniser chains for all link lines plus previous synced trig_clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= '0;
            en_sync   <= '0;
            d0_sync   <= '0;
            d1_sync   <= '0;
            tclk_prev <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], trig_clk};
            en_sync   <= {en_sync[SYNC_STAGES-2:0], trig_en};
            d0_sync   <= {d0_sync[SYNC_STAGES-2:0], trig_d0};
            d1_sync   <= {d1_sync[SYNC_STAGES-2:0], trig_d1};
            tclk_prev <= tclk_s;
        end
    end

    // Next-state and per-cycle actions of the frame FSM.
    always_comb begin
        state_n  = state;
        do_shift = 1'b0;
        err_n    = 1'b0;
        code_n   = err_code;
        good     = 1'b0;
        unique case (state)
            IDLE: begin
                if (link_edge && en_s) begin
                    do_shift = 1'b1;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                if (link_edge) begin
                    if (en_s) begin
                        do_shift = 1'b1;
                        if (pair_cnt == 5'd15) begin
                            state_n = CHECK;
                        end
                    end else begin
                        err_n   = 1'b1;
                        code_n  = 2'b01;
                        state_n = IDLE;
                    end
                end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    code_n  = 2'b10;
                    state_n = IDLE;
                end
            end
            CHECK: begin
                state_n = IDLE;
                if (bad) begin
                    err_n  = 1'b1;
                    code_n = 2'b11;
                end else begin
                    good = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register, shift register, pair and idle counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= '0;
            pair_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            state <= state_n;
            if (do_shift) begin
                shreg    <= {shreg[29:0], d1_s, d0_s};
                pair_cnt <= (state == IDLE) ? 5'd1 : pair_cnt + 5'd1;
            end else if (state_n == IDLE) begin
                pair_cnt <= '0;
            end
            if (state == SHIFT && !link_edge) begin
                idle_cnt <= idle_cnt + TW'(1);
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    // Output fields, strobes, held error cause and saturating counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            band_id     <= '0;
            phi_id      <= '0;
            bcid        <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= '0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            data_valid <= good;
            frame_err  <= err_n;
            if (good) begin
                band_id <= shreg[31:24];
                phi_id  <= shreg[23:18];
                bcid    <= shreg[17:6];
                if (frame_count != 16'hFFFF) begin
                    frame_count <= frame_count + 16'd1;
                end
            end
            if (err_n) begin
                err_code <= code_n;
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_strip_trigger_info_receiver.sv
// Directed bench for strip_trigger_info_receiver: trig_clk = clk/4,
// good, parity, reserved, truncated, timeout, back-to-back and reset frames.
module tb_strip_trigger_info_receiver;

    logic        clk;
    logic        reset;
    logic        trig_clk;
    logic        trig_en;
    logic        trig_d0;
    logic        trig_d1;
    logic [7:0]  band_id;
    logic [5:0]  phi_id;
    logic [11:0] bcid;
    logic        data_valid;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] frame_count;
    logic [15:0] err_count;

    int n_vec = 0;
    int n_err = 0;
    int dv_seen = 0;
    int fe_seen = 0;
    int exp_fc = 0;
    int exp_ec = 0;
    logic [25:0] fq[$];

    strip_trigger_info_receiver dut (
        .clk         (clk),
        .reset       (reset),
        .trig_clk    (trig_clk),
        .trig_en     (trig_en),
        .trig_d0     (trig_d0),
        .trig_d1     (trig_d1),
        .band_id     (band_id),
        .phi_id      (phi_id),
        .bcid        (bcid),
        .data_valid  (data_valid),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .frame_count (frame_count),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: counts strobes, records decoded fields.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            dv_seen++;
            fq.push_back({band_id, phi_id, bcid});
        end
        if (frame_err === 1'b1) fe_seen++;
        if (data_valid === 1'b1 || frame_err === 1'b1)
            chk("dv_fe_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
    end

    function automatic logic [31:0] mk(input logic [7:0] b,
                                       input logic [5:0] p,
                                       input logic [11:0] c,
                                       input logic [4:0] r);
        logic [31:0] f;
        f = {b, p, c, r, 1'b0};
        f[0] = ^f[31:1];
        return f;
    endfunction

    task automatic send_pair(input logic en, input logic d1, input logic d0);
        trig_en  = en;
        trig_d1  = d1;
        trig_d0  = d0;
        trig_clk = 1'b0;
        #20;
        trig_clk = 1'b1;
        #20;
    endtask

    task automatic send_pairs(input logic [31:0] f, input int n);
        for (int k = 15; k > 15 - n; k--)
            send_pair(1'b1, f[2*k+1], f[2*k]);
    endtask

    task automatic clr();
        dv_seen = 0;
        fe_seen = 0;
        fq.delete();
    endtask

    task automatic check_good(input string tag, input logic [7:0] b,
                              input logic [5:0] p, input logic [11:0] c);
        #11;
        chk({tag, "_dv_early"}, {31'd0, data_valid}, 32'd0);
        #10;
        chk({tag, "_dv"}, {31'd0, data_valid}, 32'd1);
        chk({tag, "_band"}, {24'd0, band_id}, {24'd0, b});
        chk({tag, "_phi"}, {26'd0, phi_id}, {26'd0, p});
        chk({tag, "_bcid"}, {20'd0, bcid}, {20'd0, c});
        chk({tag, "_fcount"}, {16'd0, frame_count}, exp_fc);
        chk({tag, "_fe_seen"}, fe_seen, 32'd0);
        #9;
    endtask

    task automatic check_err(input string tag, input logic [1:0] code);
        #41;
        chk({tag, "_fe_seen"}, fe_seen, 32'd1);
        chk({tag, "_dv_seen"}, dv_seen, 32'd0);
        chk({tag, "_code"}, {30'd0, err_code}, {30'd0, code});
        chk({tag, "_ecount"}, {16'd0, err_count}, exp_ec);
        chk({tag, "_fcount"}, {16'd0, frame_count}, exp_fc);
        #9;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_band"}, {24'd0, band_id}, 32'd0);
        chk({tag, "_phi"}, {26'd0, phi_id}, 32'd0);
        chk({tag, "_bcid"}, {20'd0, bcid}, 32'd0);
        chk({tag, "_dv"}, {31'd0, data_valid}, 32'd0);
        chk({tag, "_fe"}, {31'd0, frame_err}, 32'd0);
        chk({tag, "_code"}, {30'd0, err_code}, 32'd0);
        chk({tag, "_fcount"}, {16'd0, frame_count}, 32'd0);
        chk({tag, "_ecount"}, {16'd0, err_count}, 32'd0);
    endtask

    logic [31:0] f1, f2, fr, fa, fb, fc;

    initial begin
        f1 = mk(8'h5A, 6'h13, 12'hABC, 5'd0);
        f2 = mk(8'hC3, 6'h3F, 12'h001, 5'd0);
        fr = mk(8'h11, 6'h22, 12'h333, 5'b00011);
        fa = mk(8'h00, 6'h01, 12'hFFF, 5'd0);
        fb = mk(8'hFF, 6'h00, 12'h800, 5'd0);
        fc = mk(8'hA5, 6'h2A, 12'h123, 5'd0);
        reset    = 1'b0;
        trig_clk = 1'b0;
        trig_en  = 1'b0;
        trig_d0  = 1'b0;
        trig_d1  = 1'b0;
        #1;
        check_zero("reset");
        #29;
        reset = 1'b1;
        #20;

        chk("f1_parity_bit", {31'd0, f1[0]}, 32'd0);
        clr();
        send_pairs(f1, 16);
        exp_fc = 1;
        check_good("good1", 8'h5A, 6'h13, 12'hABC);

        clr();
        send_pairs(f1 | 32'd1, 16);
`ifdef STRIP_TRIG_RX_PARITY_EN
        exp_ec = 1;
        check_err("parity", 2'b11);
        chk("parity_band_held", {24'd0, band_id}, 32'h5A);
`else
        exp_fc = 2;
        check_good("parity_ignored", 8'h5A, 6'h13, 12'hABC);
        chk("parity_ecount", {16'd0, err_count}, 32'd0);
`endif

        clr();
        send_pairs(fr, 16);
        exp_ec++;
        check_err("reserved", 2'b11);
        chk("reserved_band_held", {24'd0, band_id}, 32'h5A);
        chk("reserved_bcid_held", {20'd0, bcid}, 32'hABC);

        clr();
        send_pairs(f2, 9);
        send_pair(1'b0, 1'b0, 1'b0);
        exp_ec++;
        check_err("trunc", 2'b01);
        clr();
        send_pairs(f2, 16);
        exp_fc++;
        check_good("after_trunc", 8'hC3, 6'h3F, 12'h001);

        clr();
        send_pairs(fa, 5);
        #401;
        chk("tout_early", fe_seen, 32'd0);
        #399;
        #1;
        exp_ec++;
        chk("tout_fe_seen", fe_seen, 32'd1);
        chk("tout_code", {30'd0, err_code}, 32'd2);
        chk("tout_dv_seen", dv_seen, 32'd0);
        chk("tout_ecount", {16'd0, err_count}, exp_ec);
        #9;

        clr();
        send_pairs(fa, 16);
        send_pairs(fb, 16);
        send_pairs(fc, 16);
        trig_en = 1'b0;
        #61;
        exp_fc += 3;
        chk("b2b_dv_seen", dv_seen, 32'd3);
        chk("b2b_fe_seen", fe_seen, 32'd0);
        chk("b2b_fcount", {16'd0, frame_count}, exp_fc);
        chk("b2b_f0", {6'd0, (fq.size() > 0) ? fq[0] : 26'h3FFFFFF},
            {6'd0, 8'h00, 6'h01, 12'hFFF});
        chk("b2b_f1", {6'd0, (fq.size() > 1) ? fq[1] : 26'h3FFFFFF},
            {6'd0, 8'hFF, 6'h00, 12'h800});
        chk("b2b_f2", {6'd0, (fq.size() > 2) ? fq[2] : 26'h3FFFFFF},
            {6'd0, 8'hA5, 6'h2A, 12'h123});
        #9;

        clr();
        send_pairs(f2, 8);
        reset    = 1'b0;
        trig_clk = 1'b0;
        trig_en  = 1'b0;
        #1;
        check_zero("midreset");
        #39;
        reset = 1'b1;
        #20;
        clr();
        send_pairs(f1, 16);
        exp_fc = 1;
        exp_ec = 0;
        check_good("post_reset", 8'h5A, 6'h13, 12'hABC);
        chk("post_reset_ecount", {16'd0, err_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/strip_trigger_info_receiver.md
Name: strip_trigger_info_receiver

Overview:
- Receive end of the strip trigger serial link (trig_clk / trig_en / trig_d0 / trig_d1).
- Samples the already-buffered single-ended link lines in the local clk domain and deserialises 32-bit frames.
- Checks framing and parity, then presents band_id, phi_id and BCID with a one-cycle valid strobe plus error/statistics counters.
- Used in loopback test fixtures and on the strip-side emulator board.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on all four link inputs (minimum 2).
- TIMEOUT, 64, clk cycles without a trig_clk rising edge mid-frame before the frame is aborted.

Ports:
- clk  in  1  local clock; clk frequency must be at least 4x trig_clk frequency.
- reset  in  1  asynchronous, active-low reset.
- trig_clk  in  1  forwarded link clock, asynchronous to clk.
- trig_en  in  1  frame enable; high for exactly 16 trig_clk cycles per frame.
- trig_d0  in  1  lane 0, carries even frame bits.
- trig_d1  in  1  lane 1, carries odd frame bits.
- band_id  out  8  received band id, held until next good frame.
- phi_id  out  6  received phi id, held.
- bcid  out  12  received BCID, held.
- data_valid  out  1  one-clk pulse when a good frame's fields update.
- frame_err  out  1  one-clk pulse on any rejected frame.
- err_code  out  2  cause of last error: 01 truncated, 10 timeout, 11 parity/reserved; held.
- frame_count  out  16  good frames received, saturating at 16'hFFFF.
- err_count  out  16  rejected frames, saturating at 16'hFFFF.

Behaviour:
- Reset (reset=0, async): all outputs 0, synchronisers 0, FSM to IDLE, shift register and pair counter 0.
- Synchronisation:
  - All four inputs pass through SYNC_STAGES flops.
  - A trig_clk rising edge is detected as synced trig_clk = 1 while the previous synced value = 0.
  - en, d0 and d1 are taken from the same synced stage in that same cycle.
- Frame format, 32 bits, MSB first:
  - [31:24] band_id, [23:18] phi_id, [17:6] bcid, [5:1] reserved (must be 0), [0] even parity over bits [31:0].
  - Each edge delivers one pair: d1 = bit 2k+1, d0 = bit 2k, k descending from 15 to 0.
  - Shift register does shreg <= {shreg[29:0], d1, d0}.
- FSM:
  - IDLE: on edge with en=1, shift the pair, pair_cnt=1, go to SHIFT. Edges with en=0 are ignored.
  - SHIFT, on edge with en=1: shift, pair_cnt++. When pair_cnt reaches 16, go to CHECK.
  - SHIFT, on edge with en=0: truncated frame; frame_err pulse, err_code=01, go to IDLE.
  - SHIFT, TIMEOUT clk cycles elapse with no edge: frame_err, err_code=10, go to IDLE. The idle counter resets on every edge.
  - CHECK, one clk cycle:
    - Parity fail or reserved bits != 0: frame_err, err_code=11.
    - Otherwise: register fields, data_valid=1, frame_count++.
    - Return to IDLE.
- Latency: data_valid rises exactly 2 clk cycles after the clk in which the 16th edge is detected.
- Back-to-back frames: en may stay high across frames. The 17th edge starts a new frame from IDLE; the 4x clk ratio guarantees CHECK never coincides with an edge.
- Error accounting:
  - err_count increments with every frame_err.
  - Both counters saturate and never wrap.
- frame_err and data_valid are never high in the same cycle.
- Reset asserted mid-frame discards the partial frame with no error pulse.

Optional Feature:
- Macro: STRIP_TRIG_RX_PARITY_EN.
- Defined: parity bit checked as above.
- Undefined: parity bit ignored; only reserved bits != 0 cause err_code=11. Interoperates with transmitters that send parity=0.

Test Plan:
- Frame {8'h5A, 6'h13, 12'hABC, 5'b0, 1'b0}, trig_clk = clk/4 -> data_valid once; band_id=8'h5A, phi_id=6'h13, bcid=12'hABC; frame_count=1; frame_err never high.
- Same frame with parity bit = 1 -> frame_err, err_code=11, err_count=1, outputs keep the previous values. With the macro undefined: accepted.
- trig_en dropped after 9 pairs -> frame_err, err_code=01 on the 10th edge. A following good frame then decodes correctly.
- trig_clk stopped after 5 pairs for 64 clk -> frame_err, err_code=10 at cycle 64. No data_valid.
- Three back-to-back frames with en held high (48 edges) -> three data_valid pulses, frame_count=3, each carrying its own fields.
- reset pulsed low after 8 pairs -> all outputs 0 immediately; the next complete frame decodes, err_count stays 0.
